// File: rtl/scan_chain_loader.sv
// Scan configuration chain loader: serialises streamed config words LSB-first onto si/se
// and repacks the chain's so output into readback words while the new contents shift in.
module scan_chain_loader #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  num_bits,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              se,
    output logic              si,
    input  logic              so,
    output logic              rb_valid,
    output logic [DATA_W-1:0] rb_data,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [LEN_W-1:0]  WORD_BITS = LEN_W'(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_bits_left;
    logic [LEN_W-1:0]  r_need;
    logic [IDX_W-1:0]  r_word_left;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_buf;
    logic              r_buf_full;
    logic              r_se;
    logic              r_si;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_collect;
    logic [IDX_W-1:0]  r_rb_idx;
    logic [DATA_W-1:0] r_rb_data;
    logic              r_rb_valid;

    logic              w_cfg_ready;
    logic              w_hs;
    logic [LEN_W-1:0]  w_need_next;
    logic              w_word_empty;
    logic              w_have_next;
    logic [DATA_W-1:0] w_next_src;
    logic              w_last_shift;
    logic [DATA_W-1:0] w_collect_next;

    // r_need tracks bits not yet covered by an accepted word, so ready drops once enough words are in.
    assign w_cfg_ready  = (r_need != '0) &&
                          ((r_state == S_FILL) || ((r_state == S_SHIFT) && !r_buf_full));
    assign w_hs         = cfg_valid && w_cfg_ready;
    assign w_need_next  = (r_need > WORD_BITS) ? (r_need - WORD_BITS) : '0;
    assign w_word_empty = (r_word_left == '0);
    assign w_have_next  = r_buf_full || w_hs;
    assign w_next_src   = r_buf_full ? r_buf : cfg_data;
    assign w_last_shift = r_se && (r_bits_left == '0);

    always_comb begin
        w_collect_next           = r_collect;
        w_collect_next[r_rb_idx] = so;
    end

    // r_bits_left counts bits not yet driven onto si; the bit on si now is already subtracted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bits_left <= '0;
            r_need      <= '0;
            r_word_left <= '0;
            r_shreg     <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_se        <= 1'b0;
            r_si        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_buf_full <= 1'b0;
                        if (num_bits == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_FILL;
                            r_bits_left <= num_bits;
                            r_need      <= num_bits;
                        end
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_need      <= w_need_next;
                        r_se        <= 1'b1;
                        r_si        <= cfg_data[0];
                        r_shreg     <= cfg_data >> 1;
                        r_word_left <= LAST_IDX;
                        r_bits_left <= r_bits_left - LEN_ONE;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_hs) begin
                        r_need <= w_need_next;
                    end
                    if (r_bits_left == '0) begin
                        r_se    <= 1'b0;
                        r_si    <= 1'b0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (!w_word_empty) begin
                        r_si        <= r_shreg[0];
                        r_shreg     <= r_shreg >> 1;
                        r_word_left <= r_word_left - IDX_ONE;
                        r_bits_left <= r_bits_left - LEN_ONE;
                        if (w_hs) begin
                            r_buf      <= cfg_data;
                            r_buf_full <= 1'b1;
                        end
                    end else if (w_have_next) begin
                        // A word arriving on the exhausting edge bypasses the buffer to avoid a bubble.
                        r_si        <= w_next_src[0];
                        r_shreg     <= w_next_src >> 1;
                        r_word_left <= LAST_IDX;
                        r_bits_left <= r_bits_left - LEN_ONE;
                        r_buf_full  <= 1'b0;
                    end else begin
                        r_se    <= 1'b0;
                        r_si    <= 1'b0;
                        r_state <= S_FILL;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Each se edge also clocks the old chain contents out of so; flush on a full word or the final bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_collect  <= '0;
            r_rb_idx   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (r_se) begin
                if ((r_rb_idx == LAST_IDX) || w_last_shift) begin
                    r_rb_data  <= w_collect_next;
                    r_rb_valid <= 1'b1;
                    r_collect  <= '0;
                    r_rb_idx   <= '0;
                end else begin
                    r_collect <= w_collect_next;
                    r_rb_idx  <= r_rb_idx + IDX_ONE;
                end
            end
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign se        = r_se;
    assign si        = r_si;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rb_valid  = r_rb_valid;
    assign rb_data   = r_rb_data;

endmodule
